// File: rtl/axi_lite_master_port.sv
// axi_lite_master_port: single-outstanding CPU load/store to AXI4-Lite initiator.
// Define AXI_MASTER_TIMEOUT_EN to build the TIMEOUT_CYCLES watchdog.
module axi_lite_master_port #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    input  logic [1:0]              M_AXI_BRESP,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
    state_t state, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic aw_done, w_done, timeout, unused_resp_lsb;
    assign unused_resp_lsb = M_AXI_RRESP[0] ^ M_AXI_BRESP[0];
    assign req_ready     = state == IDLE && !RST;
    assign resp_valid    = state == DONE;
    assign M_AXI_ARVALID = state == RD_ADDR;
    assign M_AXI_RREADY  = state == RD_DATA;
    assign M_AXI_AWVALID = state == WR_REQ && !aw_done;
    assign M_AXI_WVALID  = state == WR_REQ && !w_done;
    assign M_AXI_BREADY  = state == WR_RESP;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = req_valid ? (req_we ? WR_REQ : RD_ADDR) : IDLE;
            RD_ADDR: state_d = M_AXI_ARREADY ? RD_DATA : RD_ADDR;
            RD_DATA: state_d = M_AXI_RVALID ? DONE : RD_DATA;
            WR_REQ:  state_d = ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) ? WR_RESP : WR_REQ;
            WR_RESP: state_d = M_AXI_BVALID ? DONE : WR_RESP;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = DONE;
    end
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_d;
    end
    // aw_done/w_done mark per-channel handshakes so each VALID drops independently
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            aw_done <= state == WR_REQ && (aw_done || M_AXI_AWREADY);
            w_done  <= state == WR_REQ && (w_done || M_AXI_WREADY);
            if (timeout) begin
                resp_rdata <= '0;
                resp_err   <= 1'b1;
            end else if (state == RD_DATA && M_AXI_RVALID) begin
                resp_rdata <= M_AXI_RDATA;
                resp_err   <= M_AXI_RRESP[1];
            end else if (state == WR_RESP && M_AXI_BVALID) begin
                resp_rdata <= '0;
                resp_err   <= M_AXI_BRESP[1];
            end
        end
    end
`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic busy;
    assign busy    = state inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP};
    assign timeout = busy && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge CLK) begin
        cnt <= (RST || !busy) ? '0 : cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
endmodule

// File: tb/tb_axi_lite_master_port.sv
// tb_axi_lite_master_port: scoreboarded bench with a configurable AXI4-Lite responder model.
module tb_axi_lite_master_port;
    logic        CLK = 0, RST = 1;
    logic        req_valid = 0, req_we = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_wstrb = 0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic        M_AXI_AWREADY = 0, M_AXI_WREADY = 0, M_AXI_BVALID = 0, M_AXI_ARREADY = 0, M_AXI_RVALID = 0;
    logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA;
    logic [31:0] M_AXI_RDATA = 0;
    logic [3:0]  M_AXI_WSTRB;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [1:0]  M_AXI_BRESP = 0, M_AXI_RRESP = 0;

    int checks = 0, errors = 0, resp_cnt = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_v;
    logic [31:0] mem [0:63];
    int ar_delay = 0, aw_delay = 0, w_delay = 0, ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    logic r_hold = 0, r_spurious = 0, b_spurious = 0;
    logic [1:0] cfg_rresp = 0, cfg_bresp = 0;
    logic rd_pending = 0, aw_got = 0, w_got = 0, b_pending = 0;
    logic [31:0] rd_addr = 0, wa = 0, wd = 0;
    logic [3:0] ws = 0;

    axi_lite_master_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWADDR(M_AXI_AWADDR),
        .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WDATA(M_AXI_WDATA),
        .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RDATA(M_AXI_RDATA),
        .M_AXI_RRESP(M_AXI_RRESP)
    );

    always #5 CLK = ~CLK;

    // Responder bookkeeping: record handshakes seen at the clock edge
    always @(posedge CLK) begin
        if (RST) begin
            rd_pending = 0; aw_got = 0; w_got = 0; b_pending = 0;
        end else begin
            if (M_AXI_RVALID && M_AXI_RREADY) rd_pending = 0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin rd_pending = 1; rd_addr = M_AXI_ARADDR; end
            if (M_AXI_BVALID && M_AXI_BREADY) b_pending = 0;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_got = 1; wa = M_AXI_AWADDR; end
            if (M_AXI_WVALID && M_AXI_WREADY) begin w_got = 1; wd = M_AXI_WDATA; ws = M_AXI_WSTRB; end
            if (aw_got && w_got) begin
                for (int b = 0; b < 4; b++) if (ws[b]) mem[wa[7:2]][8*b +: 8] = wd[8*b +: 8];
                aw_got = 0; w_got = 0; b_pending = 1;
            end
        end
    end

    // Responder drive, away from the active edge
    always @(negedge CLK) begin
        M_AXI_ARREADY = M_AXI_ARVALID && ar_cnt >= ar_delay;
        ar_cnt = M_AXI_ARVALID ? ar_cnt + 1 : 0;
        M_AXI_AWREADY = M_AXI_AWVALID && aw_cnt >= aw_delay;
        aw_cnt = M_AXI_AWVALID ? aw_cnt + 1 : 0;
        M_AXI_WREADY = M_AXI_WVALID && w_cnt >= w_delay;
        w_cnt = M_AXI_WVALID ? w_cnt + 1 : 0;
        M_AXI_RVALID = (rd_pending && !r_hold) || r_spurious;
        M_AXI_RDATA = mem[rd_addr[7:2]];
        M_AXI_RRESP = cfg_rresp;
        M_AXI_BVALID = b_pending || b_spurious;
        M_AXI_BRESP = cfg_bresp;
    end

    // Scoreboard: every completion pulse pops one expected {err, rdata}
    always @(negedge CLK) begin
        if (resp_valid) begin
            resp_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp got err=%0b rdata=%h required no response", resp_err, resp_rdata);
            end else begin
                exp_v = exp_q.pop_front();
                if ({resp_err, resp_rdata} !== exp_v) begin
                    errors++;
                    $display("FAIL resp got err=%0b rdata=%h required err=%0b rdata=%h",
                             resp_err, resp_rdata, exp_v[32], exp_v[31:0]);
                end
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
        for (int n = 0; n < 50 && !req_ready; n++) @(negedge CLK);
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout got req_ready=%0b required 1", req_ready);
        end
        @(negedge CLK);
        req_valid = 0;
    endtask

    task automatic wait_resp(input int target);
        for (int n = 0; n < 60 && resp_cnt < target; n++) @(negedge CLK);
        checks++;
        if (resp_cnt !== target) begin
            errors++;
            $display("FAIL resp_wait got count=%0d required %0d", resp_cnt, target);
        end
    endtask

    task automatic test_reset;
        RST = 1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({req_ready, resp_valid, M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY, resp_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 00000000",
                     {req_ready, resp_valid, M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY, resp_err});
        end
        checks++;
        if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h required 0", resp_rdata); end
        RST = 0;
        @(negedge CLK);
        checks++;
        if (req_ready !== 1'b1 || M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000) begin
            errors++;
            $display("FAIL idle got ready=%0b awprot=%b arprot=%b required 1 000 000", req_ready, M_AXI_AWPROT, M_AXI_ARPROT);
        end
    endtask

    task automatic test_read;
        int base = resp_cnt;
        mem[4] = 32'hDEADBEEF;
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        send(0, 32'h10, 0, 0);
        checks++;
        if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 32'h10) begin
            errors++; $display("FAIL rd_cycle1 got arvalid=%0b araddr=%h required 1 00000010", M_AXI_ARVALID, M_AXI_ARADDR);
        end
        @(negedge CLK);
        checks++;
        if (M_AXI_RREADY !== 1'b1 || M_AXI_ARVALID !== 1'b0) begin
            errors++; $display("FAIL rd_cycle2 got rready=%0b arvalid=%0b required 1 0", M_AXI_RREADY, M_AXI_ARVALID);
        end
        @(negedge CLK);
        checks++;
        if (resp_valid !== 1'b1) begin errors++; $display("FAIL rd_cycle3 got resp_valid=%0b required 1", resp_valid); end
        wait_resp(base + 1);
    endtask

    task automatic test_write_w_first;
        int base = resp_cnt;
        mem[8] = 32'hAAAAAAAA;
        aw_delay = 3;
        exp_q.push_back(33'h0);
        send(1, 32'h20, 32'h12345678, 4'b0011);
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b11 || M_AXI_AWADDR !== 32'h20 || M_AXI_WDATA !== 32'h12345678 || M_AXI_WSTRB !== 4'b0011) begin
            errors++; $display("FAIL wr_cycle1 got aw=%0b w=%0b addr=%h data=%h strb=%b required 1 1 00000020 12345678 0011",
                               M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB);
        end
        @(negedge CLK);
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b10) begin
            errors++; $display("FAIL wr_w_drop got aw,w=%b required 10", {M_AXI_AWVALID, M_AXI_WVALID});
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== 32'h20) begin
            errors++; $display("FAIL wr_aw_hold got awvalid=%0b addr=%h required 1 00000020", M_AXI_AWVALID, M_AXI_AWADDR);
        end
        @(negedge CLK);
        checks++;
        if (M_AXI_AWVALID !== 1'b0 || M_AXI_BREADY !== 1'b1) begin
            errors++; $display("FAIL wr_resp_phase got awvalid=%0b bready=%0b required 0 1", M_AXI_AWVALID, M_AXI_BREADY);
        end
        wait_resp(base + 1);
        aw_delay = 0;
        checks++;
        if (mem[8] !== 32'hAAAA5678) begin errors++; $display("FAIL wr_mem got %h required aaaa5678", mem[8]); end
    endtask

    task automatic test_write_aw_first;
        int base = resp_cnt;
        mem[10] = 32'h0;
        w_delay = 2;
        exp_q.push_back(33'h0);
        send(1, 32'h28, 32'h11223344, 4'b1100);
        @(negedge CLK);
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b01) begin
            errors++; $display("FAIL wr_aw_drop got aw,w=%b required 01", {M_AXI_AWVALID, M_AXI_WVALID});
        end
        wait_resp(base + 1);
        w_delay = 0;
        exp_q.push_back(33'h0);
        send(1, 32'h24, 32'hCAFEF00D, 4'b1111);
        wait_resp(base + 2);
        checks++;
        if (mem[10] !== 32'h11220000 || mem[9] !== 32'hCAFEF00D) begin
            errors++; $display("FAIL wr_mem2 got %h %h required 11220000 cafef00d", mem[10], mem[9]);
        end
    endtask

    task automatic test_error;
        int base = resp_cnt;
        cfg_rresp = 2'b10;
        exp_q.push_back({1'b1, mem[4]});
        send(0, 32'h10, 0, 0);
        wait_resp(base + 1);
        cfg_rresp = 2'b01;
        exp_q.push_back({1'b0, mem[4]});
        send(0, 32'h10, 0, 0);
        wait_resp(base + 2);
        cfg_rresp = 2'b00;
        cfg_bresp = 2'b11;
        exp_q.push_back({1'b1, 32'h0});
        send(1, 32'h2C, 32'h1, 4'hF);
        wait_resp(base + 3);
        cfg_bresp = 2'b00;
    endtask

    task automatic test_back_to_back;
        int base = resp_cnt;
        mem[5] = 32'h0BADC0DE;
        exp_q.push_back({1'b0, 32'h0BADC0DE});
        exp_q.push_back(33'h0);
        req_valid = 1; req_we = 0; req_addr = 32'h14;
        for (int n = 0; n < 50 && !req_ready; n++) @(negedge CLK);
        @(negedge CLK);
        req_we = 1; req_addr = 32'h30; req_wdata = 32'h55AA55AA; req_wstrb = 4'hF;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy c%0d got req_ready=%0b required 0", c, req_ready); end
            if (c < 3) @(negedge CLK);
        end
        checks++;
        if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_done got resp_valid=%0b required 1", resp_valid); end
        @(negedge CLK);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept got req_ready=%0b required 1", req_ready); end
        @(negedge CLK);
        req_valid = 0;
        wait_resp(base + 2);
        repeat (5) @(negedge CLK);
        checks++;
        if (resp_cnt !== base + 2 || mem[12] !== 32'h55AA55AA) begin
            errors++; $display("FAIL b2b_count got %0d mem=%h required %0d 55aa55aa", resp_cnt - base, mem[12], 2);
        end
    endtask

    task automatic test_reset_mid_read;
        int base = resp_cnt;
        r_hold = 1;
        send(0, 32'h10, 0, 0);
        @(negedge CLK);
        checks++;
        if (M_AXI_RREADY !== 1'b1) begin errors++; $display("FAIL mid_rd_phase got rready=%0b required 1", M_AXI_RREADY); end
        RST = 1;
        @(negedge CLK);
        checks++;
        if ({M_AXI_RREADY, req_ready, M_AXI_ARVALID} !== 3'b000) begin
            errors++; $display("FAIL mid_rd_abort got rready,ready,arvalid=%b required 000", {M_AXI_RREADY, req_ready, M_AXI_ARVALID});
        end
        RST = 0; r_hold = 0;
        @(negedge CLK);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rd_idle got req_ready=%0b required 1", req_ready); end
        r_spurious = 1; b_spurious = 1;
        repeat (5) @(negedge CLK);
        checks++;
        if ({M_AXI_RREADY, M_AXI_BREADY} !== 2'b00) begin
            errors++; $display("FAIL spurious_ready got %b required 00", {M_AXI_RREADY, M_AXI_BREADY});
        end
        r_spurious = 0; b_spurious = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if (resp_cnt !== base) begin errors++; $display("FAIL mid_rd_noresp got %0d pulses required 0", resp_cnt - base); end
    endtask

    task automatic test_timeout;
        int base = resp_cnt;
        int hi = 0;
        ar_delay = 100000;
`ifdef AXI_MASTER_TIMEOUT_EN
        exp_q.push_back(33'h100000000);
        send(0, 32'h10, 0, 0);
        while (M_AXI_ARVALID && hi < 40) begin hi++; @(negedge CLK); end
        checks++;
        if (hi !== 16) begin errors++; $display("FAIL timeout_len got %0d required 16", hi); end
        wait_resp(base + 1);
`else
        send(0, 32'h10, 0, 0);
        for (int n = 0; n < 100; n++) begin
            if (M_AXI_ARVALID) hi++;
            @(negedge CLK);
        end
        checks++;
        if (hi !== 100 || resp_cnt !== base) begin
            errors++; $display("FAIL no_timeout got arvalid_cycles=%0d pulses=%0d required 100 0", hi, resp_cnt - base);
        end
        RST = 1;
        @(negedge CLK);
        RST = 0;
        @(negedge CLK);
`endif
        ar_delay = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset;
        test_read;
        test_write_w_first;
        test_write_aw_first;
        test_error;
        test_back_to_back;
        test_reset_mid_read;
        test_timeout;
        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d required 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
